// File: rtl/adder_seq_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_seq_ctrl_if : requester handshake plus external 5-bit adder slice bus
// Revision 1.0
// ----------------------------------------------------------------------------
interface adder_seq_ctrl_if #(
  parameter int NCHUNK = 4
);
  localparam int W = 5 * NCHUNK;

  logic         start;
  logic         subMode;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carryOut;
  logic         overflow;
  logic [4:0]   addA;
  logic [4:0]   addB;
  logic         addCin;
  logic [4:0]   addSum;
  logic         addCout;

  modport master (
    output start, subMode, opA, opB, addSum, addCout,
    input  busy, done, result, carryOut, overflow, addA, addB, addCin
  );

  modport slave (
    input  start, subMode, opA, opB, addSum, addCout,
    output busy, done, result, carryOut, overflow, addA, addB, addCin
  );
endinterface
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_seq_ctrl : multi-precision add/sub by time-sharing one 5-bit adder
// Revision 1.0
// ----------------------------------------------------------------------------
module adder_seq_ctrl #(
  parameter int NCHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_seq_ctrl_if.slave   ctrl_if
);

  localparam int W  = 5 * NCHUNK;
  localparam int IW = $clog2(NCHUNK) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [4:0]    slice_a, slice_b;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IW'(k)) begin
        slice_a = opa_q[5*k +: 5];
        slice_b = opb_q[5*k +: 5];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (ctrl_if.start) begin
          // B is stored pre-inverted so RUN never needs to know the mode
          opa_d    = ctrl_if.opA;
          opb_d    = ctrl_if.opB ^ {W{ctrl_if.subMode}};
          carry_d  = ctrl_if.subMode;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IW'(k)) begin
            result_d[5*k +: 5] = ctrl_if.addSum;
          end
        end
        carry_d = ctrl_if.addCout;
        if (idx_q == LAST_IDX) begin
          cout_d  = ctrl_if.addCout;
          ovf_d   = (opa_q[W-1] == opb_q[W-1]) & (ctrl_if.addSum[4] != opa_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ctrl_if.busy     = (state_q != IDLE);
  assign ctrl_if.done     = (state_q == DONE);
  assign ctrl_if.result   = result_q;
  assign ctrl_if.carryOut = cout_q;
  assign ctrl_if.overflow = ovf_q;
  assign ctrl_if.addA     = (state_q == RUN) ? slice_a : 5'd0;
  assign ctrl_if.addB     = (state_q == RUN) ? slice_b : 5'd0;
  assign ctrl_if.addCin   = (state_q == RUN) ? carry_q : 1'b0;

endmodule
`default_nettype wire
